// File: rtl/fb_ram_pkg.sv
// fb_ram_pkg: shared types and helpers for the dual-port framebuffer RAM.
//   fb_state_e  : clear-engine state (ST_CLEAR, ST_IDLE)
//   FB_*        : default geometry constants
//   fb_addr_ok  : word-address range check (addr < depth)
package fb_ram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } fb_state_e;

  localparam int FB_DATA_W = 16;
  localparam int FB_DEPTH  = 100000;
  localparam int FB_ADDR_W = 17;

  // Addresses at or beyond depth are errors; they never alias onto low words.
  function automatic logic fb_addr_ok(input logic [31:0] addr, input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/fb_ram_clear_ctrl.sv
// fb_ram_clear_ctrl: fill engine for fb_ram_dp.
// Walks addresses 0..DEPTH-1 once per fill, one word per cycle.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   clear       : single-cycle pulse, starts or restarts a fill
//   busy        : high while a fill is in progress (and during rst when
//                 CLEAR_ON_RESET is set)
//   fill_we     : fill write strobe for the current cycle
//   fill_addr   : word address written by the fill this cycle
module fb_ram_clear_ctrl
  import fb_ram_pkg::*;
#(
  parameter int DEPTH          = FB_DEPTH,
  parameter int ADDR_W         = FB_ADDR_W,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  output logic              busy,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_addr
);

  fb_state_e         state;
  logic [ADDR_W-1:0] cnt;
  logic              last;

  assign last = (cnt == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clear) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end
        end
        ST_CLEAR: begin
          // A clear pulse mid-fill restarts from word 0.
          if (clear) begin
            cnt <= '0;
          end else if (last) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // busy reflects the reset target while rst is held so the port A gate
  // is already correct before the first edge; no fill writes happen in reset.
  assign busy      = rst ? (CLEAR_ON_RESET != 0) : (state == ST_CLEAR);
  assign fill_we   = !rst && (state == ST_CLEAR);
  assign fill_addr = cnt;

endmodule

// File: rtl/fb_ram_dp.sv
// fb_ram_dp: parametrised dual-port framebuffer RAM with clear engine.
// Port A (draw side) reads/writes, port B (scan side) reads only. Both read
// paths are registered with one cycle of latency; read data holds between
// reads and an rvalid pulse marks each update. Same-cycle A write / B read
// of one address is read-first.
// Optional macro FB_RAM_BYTE_WE_EN adds a_be byte write enables on port A.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   clear / busy                 : fill request pulse / fill in progress
//   a_en, a_we, a_addr, a_wdata  : port A request
//   a_be                         : port A byte enables (macro builds only)
//   a_rdata, a_rvalid, a_err     : port A read data, valid pulse, range error
//   b_en, b_addr                 : port B read request
//   b_rdata, b_rvalid            : port B read data, valid pulse
module fb_ram_dp
  import fb_ram_pkg::*;
#(
  parameter int                DATA_W         = FB_DATA_W,
  parameter int                DEPTH          = FB_DEPTH,
  parameter int                ADDR_W         = FB_ADDR_W,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0,
  parameter int                CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  output logic                busy,
  input  logic                a_en,
  input  logic                a_we,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
`ifdef FB_RAM_BYTE_WE_EN
  input  logic [DATA_W/8-1:0] a_be,
`endif
  output logic [DATA_W-1:0]   a_rdata,
  output logic                a_rvalid,
  output logic                a_err,
  input  logic                b_en,
  input  logic [ADDR_W-1:0]   b_addr,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                b_rvalid
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              fill_we;
  logic [ADDR_W-1:0] fill_addr;

  fb_ram_clear_ctrl #(
    .DEPTH          (DEPTH),
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_ctrl (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .busy      (busy),
    .fill_we   (fill_we),
    .fill_addr (fill_addr)
  );

  // Request decode (stage p0). Port A is silently dropped while filling.
  logic a_ok_p0, b_ok_p0, a_req_p0, a_wr_p0, a_rd_p0, a_err_p0;

  assign a_ok_p0  = fb_addr_ok(32'(a_addr), DEPTH);
  assign b_ok_p0  = fb_addr_ok(32'(b_addr), DEPTH);
  assign a_req_p0 = a_en && !busy;
  assign a_wr_p0  = a_req_p0 && a_we && a_ok_p0;
  assign a_rd_p0  = a_req_p0 && !a_we;
  assign a_err_p0 = a_req_p0 && !a_ok_p0;

  // Shared write path: the fill engine owns it while busy.
  logic              w_en;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_data;

  assign w_en   = fill_we ? 1'b1 : a_wr_p0;
  assign w_idx  = fill_we ? fill_addr[IDX_W-1:0] : a_addr[IDX_W-1:0];
  assign w_data = fill_we ? CLEAR_VALUE : a_wdata;

`ifdef FB_RAM_BYTE_WE_EN
  localparam int NBYTES = DATA_W / 8;
  logic [NBYTES-1:0] w_be;
  assign w_be = fill_we ? {NBYTES{1'b1}} : a_be;

  always_ff @(posedge clk) begin
    if (w_en) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (w_be[i]) mem[w_idx][i*8 +: 8] <= w_data[i*8 +: 8];
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (w_en) mem[w_idx] <= w_data;
  end
`endif

  // Read registers (stage p1). Nonblocking memory update gives read-first.
  logic [DATA_W-1:0] a_rdata_p1, b_rdata_p1;
  logic              a_vld_p1, b_vld_p1, a_err_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata_p1 <= '0;
      b_rdata_p1 <= '0;
      a_vld_p1   <= 1'b0;
      b_vld_p1   <= 1'b0;
      a_err_p1   <= 1'b0;
    end else begin
      a_vld_p1 <= a_rd_p0;
      a_err_p1 <= a_err_p0;
      b_vld_p1 <= b_en;
      if (a_rd_p0) begin
        a_rdata_p1 <= a_ok_p0 ? mem[a_addr[IDX_W-1:0]] : '0;
      end
      if (b_en) begin
        if (!b_ok_p0)  b_rdata_p1 <= '0;
        else if (busy) b_rdata_p1 <= CLEAR_VALUE;
        else           b_rdata_p1 <= mem[b_addr[IDX_W-1:0]];
      end
    end
  end

  assign a_rdata  = a_rdata_p1;
  assign a_rvalid = a_vld_p1;
  assign a_err    = a_err_p1;
  assign b_rdata  = b_rdata_p1;
  assign b_rvalid = b_vld_p1;

endmodule

// File: tb/tb_fb_ram_dp.sv
// tb_fb_ram_dp: self-checking bench for fb_ram_dp (DEPTH=16, CLEAR_VALUE=A5A5).
// A behavioural model (word array, fill-cycles-remaining count, held read
// values) predicts every output each cycle; directed sequences add fixed
// expected values on top. Build with FB_RAM_BYTE_WE_EN to cover byte enables.
module tb_fb_ram_dp;

  localparam int          DATA_W = 16;
  localparam int          DEPTH  = 16;
  localparam int          ADDR_W = 5;
  localparam logic [15:0] CV     = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst, clear, busy;
  logic        a_en, a_we, a_rvalid, a_err;
  logic [4:0]  a_addr, b_addr;
  logic [15:0] a_wdata, a_rdata, b_rdata;
  logic        b_en, b_rvalid;
`ifdef FB_RAM_BYTE_WE_EN
  logic [1:0]  a_be;
`endif

  always #5 clk = ~clk;

  fb_ram_dp #(
    .DATA_W         (DATA_W),
    .DEPTH          (DEPTH),
    .ADDR_W         (ADDR_W),
    .CLEAR_VALUE    (CV),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .busy     (busy),
    .a_en     (a_en),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
`ifdef FB_RAM_BYTE_WE_EN
    .a_be     (a_be),
`endif
    .a_rdata  (a_rdata),
    .a_rvalid (a_rvalid),
    .a_err    (a_err),
    .b_en     (b_en),
    .b_addr   (b_addr),
    .b_rdata  (b_rdata),
    .b_rvalid (b_rvalid)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] ref_mem [DEPTH];
  int          fill_left = 0;
  logic [15:0] ref_a = '0;
  logic [15:0] ref_b = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic idle_in();
    clear = 1'b0; a_en = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_en = 1'b0; b_addr = '0;
`ifdef FB_RAM_BYTE_WE_EN
    a_be = 2'b11;
`endif
  endtask

  function automatic logic [15:0] merged(input logic [15:0] old);
    logic [15:0] n;
    n = old;
`ifdef FB_RAM_BYTE_WE_EN
    for (int i = 0; i < 2; i++) if (a_be[i]) n[i*8 +: 8] = a_wdata[i*8 +: 8];
`else
    n = a_wdata;
`endif
    return n;
  endfunction

  // One clock: predict from current inputs, advance, compare all outputs.
  task automatic tick();
    logic eb, areq, ain, bin, eav, eae;
    eb = rst ? 1'b1 : (fill_left > 0);
    chk("busy", {31'd0, busy}, {31'd0, eb});
    if (rst) begin
      @(posedge clk); #1;
      fill_left = DEPTH;
      ref_a = '0; ref_b = '0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = CV;
      chk("rst_a_rvalid", {31'd0, a_rvalid}, 0);
      chk("rst_a_err",    {31'd0, a_err},    0);
      chk("rst_b_rvalid", {31'd0, b_rvalid}, 0);
      chk("rst_a_rdata",  {16'd0, a_rdata},  0);
      chk("rst_b_rdata",  {16'd0, b_rdata},  0);
      return;
    end
    areq = a_en && !eb;
    ain  = (a_addr < DEPTH);
    bin  = (b_addr < DEPTH);
    eav  = areq && !a_we;
    eae  = areq && !ain;
    if (eav)  ref_a = ain ? ref_mem[a_addr[3:0]] : 16'h0;
    if (b_en) ref_b = !bin ? 16'h0 : (eb ? CV : ref_mem[b_addr[3:0]]);
    if (areq && a_we && ain) ref_mem[a_addr[3:0]] = merged(ref_mem[a_addr[3:0]]);
    if (clear) begin
      fill_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = CV;
    end else if (fill_left > 0) begin
      fill_left--;
    end
    @(posedge clk); #1;
    chk("a_rvalid", {31'd0, a_rvalid}, {31'd0, eav});
    chk("a_err",    {31'd0, a_err},    {31'd0, eae});
    chk("a_rdata",  {16'd0, a_rdata},  {16'd0, ref_a});
    chk("b_rvalid", {31'd0, b_rvalid}, {31'd0, b_en});
    chk("b_rdata",  {16'd0, b_rdata},  {16'd0, ref_b});
  endtask

  // Counts busy cycles (bounded); optionally pulses clear on busy cycle n.
  task automatic busy_len(input int pulse_at, output int n);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      if (!busy) break;
      n++;
      clear = (n == pulse_at);
      tick();
      clear = 1'b0;
    end
  endtask

  task automatic scan_b(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      b_en = 1'b1; b_addr = 5'(i);
      tick();
      chk(tag, {16'd0, b_rdata}, {16'd0, ref_mem[i]});
    end
    b_en = 1'b0;
  endtask

  task automatic a_op(input logic we, input logic [4:0] addr, input logic [15:0] d);
    a_en = 1'b1; a_we = we; a_addr = addr; a_wdata = d;
    tick();
    a_en = 1'b0; a_we = 1'b0;
  endtask

  initial begin
    int n;
    idle_in();
    rst = 1'b1;
    #1;
    tick(); tick(); tick();
    rst = 1'b0;

    // Reset release: 16 busy cycles, then memory reads back as the fill word.
    busy_len(0, n);
    chk("reset_fill_len", n, 16);
    scan_b("reset_scan");
    for (int i = 0; i < DEPTH; i++) chk("reset_mem", {16'd0, ref_mem[i]}, {16'd0, CV});

    // A write then A read, data held afterwards.
    a_op(1'b1, 5'd5, 16'h1234);
    a_op(1'b0, 5'd5, 16'h0000);
    chk("a_read_data",  {16'd0, a_rdata}, 32'h1234);
    chk("a_read_valid", {31'd0, a_rvalid}, 1);
    tick();
    chk("a_read_hold", {16'd0, a_rdata}, 32'h1234);

    // Collision: read-first on port B.
    a_op(1'b1, 5'd3, 16'h0001);
    a_en = 1'b1; a_we = 1'b1; a_addr = 5'd3; a_wdata = 16'hBEEF;
    b_en = 1'b1; b_addr = 5'd3;
    tick();
    a_en = 1'b0; a_we = 1'b0;
    chk("collide_old", {16'd0, b_rdata}, 32'h0001);
    tick();
    chk("collide_new", {16'd0, b_rdata}, 32'hBEEF);
    b_en = 1'b0;

    // Out-of-range accesses.
    a_op(1'b1, 5'd20, 16'hDEAD);
    chk("oor_wr_err", {31'd0, a_err}, 1);
    tick();
    chk("oor_err_pulse", {31'd0, a_err}, 0);
    scan_b("oor_scan");
    a_op(1'b0, 5'd20, 16'h0000);
    chk("oor_rd_data",  {16'd0, a_rdata}, 0);
    chk("oor_rd_valid", {31'd0, a_rvalid}, 1);
    chk("oor_rd_err",   {31'd0, a_err}, 1);

    // Clear, restarted by a second clear on busy cycle 5.
    clear = 1'b1; tick(); clear = 1'b0;
    busy_len(5, n);
    chk("clear_restart_len", n, 21);
    scan_b("clear_scan");

    // Reset in the middle of a fill.
    a_op(1'b1, 5'd9, 16'h5555);
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    busy_len(0, n);
    chk("rst_midfill_len", n, 16);
    scan_b("rst_midfill_scan");

`ifdef FB_RAM_BYTE_WE_EN
    a_be = 2'b11;
    a_op(1'b1, 5'd7, 16'h1111);
    a_be = 2'b10;
    a_op(1'b1, 5'd7, 16'hFFFF);
    a_be = 2'b11;
    a_op(1'b0, 5'd7, 16'h0000);
    chk("byte_we", {16'd0, a_rdata}, 32'hFF11);
`endif

    // Randomized traffic, including requests during fills and rare clears.
    for (int c = 0; c < 400; c++) begin
      a_en    = ($urandom_range(0, 3) != 0);
      a_we    = $urandom_range(0, 1) == 1;
      a_addr  = 5'($urandom_range(0, 19));
      a_wdata = 16'($urandom);
      b_en    = ($urandom_range(0, 3) != 0);
      b_addr  = 5'($urandom_range(0, 19));
      clear   = ($urandom_range(0, 149) == 0);
`ifdef FB_RAM_BYTE_WE_EN
      a_be    = 2'($urandom_range(0, 3));
`endif
      tick();
    end
    idle_in();
    for (int i = 0; i < 20; i++) tick();
    scan_b("final_scan");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
